// File: rtl/if_id_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe_ctrl_if
// Description : Signal bundle between the fetch-side pipeline controller and
//               its neighbours (instruction memory, decode, hazard unit and
//               debug unit). Signal names are seen from the controller side.
//               master = environment driving the controller, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_pipe_ctrl_if #(
  parameter int NB_DATA      = 32,
  parameter int NB_PC        = 32,
  parameter int NB_CTRL      = 18,
  parameter int NB_STALL_CNT = 16
);
  logic                    i_enable;
  logic                    i_enable_pc;
  logic                    i_enable_IF_ID_reg;
  logic                    i_select_control_nop;
  logic                    i_branch_taken;
  logic [NB_PC-1:0]        i_branch_target;
  logic [NB_DATA-1:0]      i_instruction;
  logic [NB_CTRL-1:0]      i_control_signals;
  logic [NB_PC-1:0]        o_pc;
  logic [NB_DATA-1:0]      o_IF_ID_instruction;
  logic [NB_PC-1:0]        o_IF_ID_pc_plus4;
  logic [NB_CTRL-1:0]      o_ID_EX_control;
  logic [NB_STALL_CNT-1:0] o_stall_count;
  logic                    o_halt;

  modport master (
    output i_enable, i_enable_pc, i_enable_IF_ID_reg, i_select_control_nop,
    output i_branch_taken, i_branch_target, i_instruction, i_control_signals,
    input  o_pc, o_IF_ID_instruction, o_IF_ID_pc_plus4, o_ID_EX_control,
    input  o_stall_count, o_halt
  );

  modport slave (
    input  i_enable, i_enable_pc, i_enable_IF_ID_reg, i_select_control_nop,
    input  i_branch_taken, i_branch_target, i_instruction, i_control_signals,
    output o_pc, o_IF_ID_instruction, o_IF_ID_pc_plus4, o_ID_EX_control,
    output o_stall_count, o_halt
  );
endinterface
`default_nettype wire

// File: rtl/if_id_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe_ctrl
// Description : Fetch-side pipeline controller for a 5-stage MIPS core. Holds
//               the PC, the IF/ID register, the ID/EX control bundle (with
//               NOP substitution on load-use stalls), a halt-drain FSM and a
//               saturating stall counter.
//               Optional macro BRANCH_DELAY_SLOT_EN: a taken branch keeps the
//               delay-slot instruction in IF/ID instead of flushing it.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe_ctrl #(
  parameter int               NB_DATA      = 32,
  parameter int               NB_PC        = 32,
  parameter int               NB_CTRL      = 18,
  parameter int               NB_STALL_CNT = 16,
  parameter logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFFFFFF,
  parameter int               DRAIN_CYCLES = 4
) (
  input  wire logic          i_clock,
  input  wire logic          i_reset,
  if_id_pipe_ctrl_if.slave   bus
);

  localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_DRAIN_W-1:0]    r_drain_cnt;
  logic [c_DRAIN_W-1:0]    w_drain_next;

  logic [NB_PC-1:0]        r_pc;
  logic [NB_DATA-1:0]      r_ifid_instr;
  logic [NB_PC-1:0]        r_ifid_pc4;
  logic [NB_CTRL-1:0]      r_idex_ctrl;
  logic [NB_STALL_CNT-1:0] r_stall_cnt;

  logic                    w_branch_eff;
  logic                    w_flush;
  logic                    w_ifid_load;
  logic [NB_PC-1:0]        w_pc_plus4;

  // Branch qualification: a stall in either register means the ID operands
  // are stale, so the branch is dropped and re-evaluated next cycle.
  always_comb begin
    w_pc_plus4   = r_pc + NB_PC'(4);
    w_branch_eff = bus.i_branch_taken & bus.i_enable_pc & bus.i_enable_IF_ID_reg;
`ifdef BRANCH_DELAY_SLOT_EN
    w_flush      = 1'b0;
`else
    w_flush      = w_branch_eff;
`endif
    w_ifid_load  = (r_state == ST_RUN) & bus.i_enable_IF_ID_reg & ~w_flush;
  end

  // Halt-drain FSM next state and drain countdown.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_ifid_load && (bus.i_instruction == HALT_INSTR)) begin
          w_state_next = ST_DRAIN;
          w_drain_next = c_DRAIN_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_next = ST_HALTED;
        end else begin
          w_drain_next = r_drain_cnt - 1'b1;
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // FSM state register; advances only on enabled cycles.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else if (bus.i_enable) begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  // PC, IF/ID, ID/EX and stall counter; hazard inputs only matter in RUN.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc         <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_idex_ctrl  <= '0;
      r_stall_cnt  <= '0;
    end else if (bus.i_enable) begin
      case (r_state)
        ST_RUN: begin
          if (bus.i_enable_pc) begin
            r_pc <= w_branch_eff ? bus.i_branch_target : w_pc_plus4;
          end
          if (bus.i_enable_IF_ID_reg) begin
            if (w_flush) begin
              r_ifid_instr <= '0;
              r_ifid_pc4   <= '0;
            end else begin
              r_ifid_instr <= bus.i_instruction;
              r_ifid_pc4   <= w_pc_plus4;
            end
          end
          r_idex_ctrl <= bus.i_select_control_nop ? '0 : bus.i_control_signals;
          if (bus.i_select_control_nop && (r_stall_cnt != {NB_STALL_CNT{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The halt word is replaced by a NOP so decode never sees it again.
          r_ifid_instr <= '0;
          r_idex_ctrl  <= bus.i_control_signals;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_pc                = r_pc;
  assign bus.o_IF_ID_instruction = r_ifid_instr;
  assign bus.o_IF_ID_pc_plus4    = r_ifid_pc4;
  assign bus.o_ID_EX_control     = r_idex_ctrl;
  assign bus.o_stall_count       = r_stall_cnt;
  assign bus.o_halt              = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_pipe_ctrl
// Description : Self-checking bench for if_id_pipe_ctrl: directed steps from
//               the test plan followed by randomized cycles, all compared
//               against a behavioural model of the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_ctrl;

  localparam int NB_DATA      = 32;
  localparam int NB_PC        = 32;
  localparam int NB_CTRL      = 18;
  localparam int NB_STALL_CNT = 2;
  localparam int DRAIN_CYCLES = 4;
  localparam logic [31:0] c_HALT = 32'hFFFFFFFF;
  localparam int c_STALL_MAX  = (1 << NB_STALL_CNT) - 1;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit c_DS = 1'b1;
`else
  localparam bit c_DS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  if_id_pipe_ctrl_if #(
    .NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_CTRL(NB_CTRL), .NB_STALL_CNT(NB_STALL_CNT)
  ) bus ();

  if_id_pipe_ctrl #(
    .NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_CTRL(NB_CTRL), .NB_STALL_CNT(NB_STALL_CNT),
    .HALT_INSTR(c_HALT), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = running, 1 = draining, 2 = halted.
  logic [31:0] m_pc, m_ins, m_p4;
  logic [17:0] m_ctrl;
  int          m_stall, m_mode, m_left;

  task automatic model_reset();
    m_pc = 0; m_ins = 0; m_p4 = 0; m_ctrl = 0; m_stall = 0; m_mode = 0; m_left = 0;
  endtask

  task automatic model_edge();
    logic        br;
    logic [31:0] old_pc;
    if (rst) begin
      model_reset();
    end else if (bus.i_enable) begin
      if (m_mode == 1) begin
        m_ins  = 0;
        m_ctrl = bus.i_control_signals;
        if (m_left == 0) m_mode = 2;
        else m_left = m_left - 1;
      end else if (m_mode == 0) begin
        old_pc = m_pc;
        br = bus.i_branch_taken && bus.i_enable_pc && bus.i_enable_IF_ID_reg;
        if (bus.i_enable_pc) m_pc = br ? bus.i_branch_target : old_pc + 32'd4;
        if (bus.i_enable_IF_ID_reg) begin
          if (br && !c_DS) begin
            m_ins = 0;
            m_p4  = 0;
          end else begin
            m_ins = bus.i_instruction;
            m_p4  = old_pc + 32'd4;
            if (bus.i_instruction == c_HALT) begin
              m_mode = 1;
              m_left = DRAIN_CYCLES - 1;
            end
          end
        end
        m_ctrl = bus.i_select_control_nop ? 18'd0 : bus.i_control_signals;
        if (bus.i_select_control_nop && m_stall < c_STALL_MAX) m_stall = m_stall + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc",    64'(bus.o_pc), 64'(m_pc));
    chk("ifid_instr", 64'(bus.o_IF_ID_instruction), 64'(m_ins));
    chk("ifid_pc4",   64'(bus.o_IF_ID_pc_plus4), 64'(m_p4));
    chk("idex_ctrl",  64'(bus.o_ID_EX_control), 64'(m_ctrl));
    chk("stall_cnt",  64'(bus.o_stall_count), 64'(m_stall));
    chk("halt",       64'(bus.o_halt), 64'(m_mode == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_idle(input logic [31:0] instr);
    bus.i_enable             = 1'b1;
    bus.i_enable_pc          = 1'b1;
    bus.i_enable_IF_ID_reg   = 1'b1;
    bus.i_select_control_nop = 1'b0;
    bus.i_branch_taken       = 1'b0;
    bus.i_branch_target      = 32'h0;
    bus.i_instruction        = instr;
    bus.i_control_signals    = 18'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    set_idle(32'h20010005);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Three clean fetches.
    for (int i = 0; i < 3; i++) step();
    chk("plan_pc_0c",   64'(bus.o_pc), 64'h0C);
    chk("plan_pc4_0c",  64'(bus.o_IF_ID_pc_plus4), 64'h0C);
    chk("plan_instr",   64'(bus.o_IF_ID_instruction), 64'h20010005);
    step();

    // Load-use stall at PC 0x10.
    bus.i_enable_pc = 1'b0; bus.i_enable_IF_ID_reg = 1'b0; bus.i_select_control_nop = 1'b1;
    bus.i_control_signals = 18'h2AAAA;
    step();
    chk("stall_pc",     64'(bus.o_pc), 64'h10);
    chk("stall_pc4",    64'(bus.o_IF_ID_pc_plus4), 64'h10);
    chk("stall_nop",    64'(bus.o_ID_EX_control), 64'h0);
    chk("stall_count1", 64'(bus.o_stall_count), 64'h1);

    // Taken branch without stall.
    set_idle(32'h00000020);
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h40;
    step();
    chk("branch_pc",    64'(bus.o_pc), 64'h40);
    chk("branch_instr", 64'(bus.o_IF_ID_instruction), c_DS ? 64'h20 : 64'h0);

    // Taken branch under a PC stall is ignored.
    bus.i_enable_pc = 1'b0; bus.i_branch_target = 32'h80;
    step();
    chk("branch_stalled_pc", 64'(bus.o_pc), 64'h40);

    // Global enable low: nothing moves.
    for (int i = 0; i < 5; i++) begin
      bus.i_enable = 1'b0;
      bus.i_enable_pc = 1'($urandom); bus.i_enable_IF_ID_reg = 1'($urandom);
      bus.i_select_control_nop = 1'($urandom); bus.i_branch_taken = 1'($urandom);
      bus.i_branch_target = $urandom; bus.i_instruction = $urandom;
      bus.i_control_signals = 18'($urandom);
      step();
      chk("frozen_pc", 64'(bus.o_pc), 64'h40);
    end

    // Halt: fetched at 0x40, PC advances once then freezes, halt after 4 cycles.
    set_idle(c_HALT);
    step();
    chk("halt_loaded", 64'(bus.o_IF_ID_instruction), 64'(c_HALT));
    set_idle(32'h20010005);
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h100; bus.i_select_control_nop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_no_halt", 64'(bus.o_halt), 64'h0);
    end
    step();
    chk("halt_rise",   64'(bus.o_halt), 64'h1);
    chk("halt_pc",     64'(bus.o_pc), 64'h44);
    chk("halt_nop",    64'(bus.o_IF_ID_instruction), 64'h0);
    step();
    step();

    // Reset out of HALTED, then reset asynchronously in the middle of a drain.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_idle(32'h20010005);
    step();
    bus.i_instruction = c_HALT;
    step();
    bus.i_instruction = 32'h20010005;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc",   64'(bus.o_pc), 64'h0);
    chk("async_rst_halt", 64'(bus.o_halt), 64'h0);
    chk("async_rst_ins",  64'(bus.o_IF_ID_instruction), 64'h0);
    model_reset();
    #1;
    rst = 1'b0;
    step();

    // Stall counter saturation.
    bus.i_select_control_nop = 1'b1; bus.i_enable_pc = 1'b0; bus.i_enable_IF_ID_reg = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("stall_saturate", 64'(bus.o_stall_count), 64'(c_STALL_MAX));

    // Randomized cycles against the model.
    for (int i = 0; i < 600; i++) begin
      rst                      = ($urandom_range(0, 39) == 0);
      bus.i_enable             = ($urandom_range(0, 7) != 0);
      bus.i_enable_pc          = ($urandom_range(0, 3) != 0);
      bus.i_enable_IF_ID_reg   = ($urandom_range(0, 3) != 0);
      bus.i_select_control_nop = ($urandom_range(0, 3) == 0);
      bus.i_branch_taken       = ($urandom_range(0, 3) == 0);
      bus.i_branch_target      = $urandom & 32'hFFFF_FFFC;
      bus.i_instruction        = ($urandom_range(0, 15) == 0) ? c_HALT : $urandom;
      bus.i_control_signals    = 18'($urandom);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
